// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: arbitrates four read requesters onto four read banks with preemption and tagged responses.
// Optional macro BANK_ARB_RR_EN selects per-bank round-robin; otherwise fixed priority B > A > C > D.
`default_nettype none

module mem_bank_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            i_req_valid,
  input  logic [ADDR_WIDTH+1:0] i_req_addr_a,
  input  logic [ADDR_WIDTH+1:0] i_req_addr_b,
  input  logic [ADDR_WIDTH+1:0] i_req_addr_c,
  input  logic [ADDR_WIDTH+1:0] i_req_addr_d,
  output logic [3:0]            o_req_ready,
  output logic [3:0]            o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data_a,
  output logic [DATA_WIDTH-1:0] o_rsp_data_b,
  output logic [DATA_WIDTH-1:0] o_rsp_data_c,
  output logic [DATA_WIDTH-1:0] o_rsp_data_d,
  input  logic                  i_ctrl_en,
  input  logic [ADDR_WIDTH-1:0] i_ctrl_addr,
  input  logic                  i_uinst_en,
  input  logic [ADDR_WIDTH-1:0] i_uinst_addr,
  output logic                  o_ctrl_rsp_valid,
  output logic                  o_uinst_rsp_valid,
  output logic [3:0]            o_mem_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_0,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_1,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_2,
  output logic [ADDR_WIDTH-1:0] o_mem_addr_3,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data_0,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data_1,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data_2,
  input  logic [DATA_WIDTH-1:0] i_mem_rd_data_3,
  output logic [15:0]           o_conflict_cnt
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  logic [3:0][ADDR_WIDTH+1:0] w_req_addr;
  logic [3:0][1:0]            w_req_bank;
  logic [3:0][DATA_WIDTH-1:0] w_rd_data;
  logic [3:0][ADDR_WIDTH-1:0] w_pre_addr;
  logic [3:0][ADDR_WIDTH-1:0] w_mem_addr;
  logic [3:0][DATA_WIDTH-1:0] w_rsp_data;
  logic [3:0]                 w_preempt;
  logic [3:0]                 w_grant;
  logic [3:0][1:0]            w_win_idx;
  logic [3:0]                 w_bank_busy;
  logic [3:0]                 w_ready_raw;
  logic [3:0]                 w_pre_deny;
  logic                       w_conflict;

  logic [3:0]                 r_pend;
  logic [3:0][1:0]            r_src;
  logic                       r_ctrl_rsp_valid;
  logic                       r_uinst_rsp_valid;
  logic [15:0]                r_conflict_cnt;

  assign w_req_addr = {i_req_addr_d, i_req_addr_c, i_req_addr_b, i_req_addr_a};
  assign w_rd_data  = {i_mem_rd_data_3, i_mem_rd_data_2, i_mem_rd_data_1, i_mem_rd_data_0};
  assign w_preempt  = {1'b0, i_uinst_en, 1'b0, i_ctrl_en};
  assign w_pre_addr = {{ADDR_WIDTH{1'b0}}, i_uinst_addr, {ADDR_WIDTH{1'b0}}, i_ctrl_addr};

  generate
    for (genvar k = 0; k < 4; k++) begin : g_bank
      logic [3:0]            w_cand;
      logic                  w_vld;
      logic [1:0]            w_idx;
      logic [ADDR_WIDTH-1:0] w_maddr;

      always_comb begin
        w_cand = 4'b0000;
        for (int r = 0; r < 4; r++) begin
          w_cand[r] = i_req_valid[r] && (w_req_bank[r] == 2'(k));
        end
      end

`ifdef BANK_ARB_RR_EN
      logic [1:0] r_ptr;

      // Search starts at the pointer and wraps modulo 4.
      always_comb begin
        w_vld = 1'b0;
        w_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
          if (!w_vld && w_cand[r_ptr + 2'(i)]) begin
            w_vld = 1'b1;
            w_idx = r_ptr + 2'(i);
          end
        end
      end

      // A preempted bank has no grant, so its pointer holds.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ptr <= 2'd0;
        end else if (w_grant[k]) begin
          r_ptr <= w_idx + 2'd1;
        end
      end
`else
      localparam logic [7:0] C_ORDER = {2'd3, 2'd2, 2'd0, 2'd1};

      always_comb begin
        w_vld = 1'b0;
        w_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
          if (!w_vld && w_cand[C_ORDER[2*i +: 2]]) begin
            w_vld = 1'b1;
            w_idx = C_ORDER[2*i +: 2];
          end
        end
      end
`endif

      always_comb begin
        w_maddr = '0;
        if (w_preempt[k]) begin
          w_maddr = w_pre_addr[k];
        end else if (w_vld) begin
          w_maddr = w_req_addr[w_idx][ADDR_WIDTH-1:0];
        end
      end

      assign w_grant[k]     = w_vld & ~w_preempt[k];
      assign w_win_idx[k]   = w_idx;
      assign w_bank_busy[k] = w_vld | w_preempt[k];
      assign w_mem_addr[k]  = w_maddr;
    end

    for (genvar r = 0; r < 4; r++) begin : g_req
      assign w_req_bank[r]  = w_req_addr[r][ADDR_WIDTH+1:ADDR_WIDTH];
      assign w_ready_raw[r] = i_req_valid[r] & w_grant[w_req_bank[r]]
                            & (w_win_idx[w_req_bank[r]] == 2'(r));
      assign w_pre_deny[r]  = i_req_valid[r] & w_preempt[w_req_bank[r]];
      assign w_rsp_data[r]  = r_pend[r] ? w_rd_data[r_src[r]] : '0;
    end
  endgenerate

  // Any valid requester on a non-preempted bank that lost must have lost to another requester.
  assign w_conflict = |(i_req_valid & ~w_ready_raw & ~w_pre_deny);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend            <= 4'b0000;
      r_src             <= '0;
      r_ctrl_rsp_valid  <= 1'b0;
      r_uinst_rsp_valid <= 1'b0;
      r_conflict_cnt    <= 16'd0;
    end else begin
      r_pend            <= w_ready_raw;
      r_ctrl_rsp_valid  <= i_ctrl_en;
      r_uinst_rsp_valid <= i_uinst_en;
      for (int r = 0; r < 4; r++) begin
        if (w_ready_raw[r]) begin
          r_src[r] <= w_req_bank[r];
        end
      end
      if (w_conflict && (r_conflict_cnt != C_CNT_MAX)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
    end
  end

  assign o_req_ready       = w_ready_raw & {4{rst_n}};
  assign o_mem_en          = w_bank_busy & {4{rst_n}};
  assign o_mem_addr_0      = w_mem_addr[0];
  assign o_mem_addr_1      = w_mem_addr[1];
  assign o_mem_addr_2      = w_mem_addr[2];
  assign o_mem_addr_3      = w_mem_addr[3];
  assign o_rsp_valid       = r_pend;
  assign o_rsp_data_a      = w_rsp_data[0];
  assign o_rsp_data_b      = w_rsp_data[1];
  assign o_rsp_data_c      = w_rsp_data[2];
  assign o_rsp_data_d      = w_rsp_data[3];
  assign o_ctrl_rsp_valid  = r_ctrl_rsp_valid;
  assign o_uinst_rsp_valid = r_uinst_rsp_valid;
  assign o_conflict_cnt    = r_conflict_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mem_bank_arbiter.sv
// tb_mem_bank_arbiter: directed-vector bench for mem_bank_arbiter with a simple synchronous RAM model.
`default_nettype none

module tb_mem_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'b0000;
  logic [13:0] addr_a = '0, addr_b = '0, addr_c = '0, addr_d = '0;
  logic        ctrl_en = 1'b0, uinst_en = 1'b0;
  logic [11:0] ctrl_addr = '0, uinst_addr = '0;
  logic [3:0]  req_ready, rsp_valid, mem_en;
  logic [63:0] rsp_a, rsp_b, rsp_c, rsp_d;
  logic        ctrl_rv, uinst_rv;
  logic [11:0] maddr0, maddr1, maddr2, maddr3;
  logic [63:0] rd0, rd1, rd2, rd3;
  logic [15:0] cnt;

  int n_vec = 0;
  int n_err = 0;

  mem_bank_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid),
    .i_req_addr_a(addr_a), .i_req_addr_b(addr_b), .i_req_addr_c(addr_c), .i_req_addr_d(addr_d),
    .o_req_ready(req_ready), .o_rsp_valid(rsp_valid),
    .o_rsp_data_a(rsp_a), .o_rsp_data_b(rsp_b), .o_rsp_data_c(rsp_c), .o_rsp_data_d(rsp_d),
    .i_ctrl_en(ctrl_en), .i_ctrl_addr(ctrl_addr),
    .i_uinst_en(uinst_en), .i_uinst_addr(uinst_addr),
    .o_ctrl_rsp_valid(ctrl_rv), .o_uinst_rsp_valid(uinst_rv),
    .o_mem_en(mem_en),
    .o_mem_addr_0(maddr0), .o_mem_addr_1(maddr1), .o_mem_addr_2(maddr2), .o_mem_addr_3(maddr3),
    .i_mem_rd_data_0(rd0), .i_mem_rd_data_1(rd1), .i_mem_rd_data_2(rd2), .i_mem_rd_data_3(rd3),
    .o_conflict_cnt(cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input int k, input logic [11:0] a);
    return {16'hCAFE, 16'(k), 20'h0, a};
  endfunction

  always @(posedge clk) begin
    if (mem_en[0]) rd0 <= mk(0, maddr0);
    if (mem_en[1]) rd1 <= mk(1, maddr1);
    if (mem_en[2]) rd2 <= mk(2, maddr2);
    if (mem_en[3]) rd3 <= mk(3, maddr3);
  end

  task automatic set_req(input logic [3:0] v, input logic [13:0] a, input logic [13:0] b,
                         input logic [13:0] c, input logic [13:0] d);
    req_valid = v; addr_a = a; addr_b = b; addr_c = c; addr_d = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    set_req(4'b0000, '0, '0, '0, '0);
    ctrl_en = 1'b0; uinst_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_req(4'b1111, {2'd0, 12'h001}, {2'd1, 12'h002}, {2'd2, 12'h003}, {2'd3, 12'h004});
    ctrl_en = 1'b1;
    #2;
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
    n_vec++; if (mem_en !== 4'b0000) begin n_err++; $display("FAIL rst_mem_en: got %b expected 0000", mem_en); end
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL rst_rsp_valid: got %b expected 0000", rsp_valid); end
    n_vec++; if (ctrl_rv !== 1'b0) begin n_err++; $display("FAIL rst_ctrl_rv: got %b expected 0", ctrl_rv); end
    n_vec++; if (cnt !== 16'd0) begin n_err++; $display("FAIL rst_cnt: got %h expected 0000", cnt); end
    do_reset();
  endtask

  task automatic test_no_conflict();
    do_reset();
    set_req(4'b1111, {2'd0, 12'h005}, {2'd1, 12'h010}, {2'd2, 12'h020}, {2'd3, 12'h030});
    #1;
    n_vec++; if (req_ready !== 4'b1111) begin n_err++; $display("FAIL nc_ready: got %b expected 1111", req_ready); end
    n_vec++; if (mem_en !== 4'b1111) begin n_err++; $display("FAIL nc_mem_en: got %b expected 1111", mem_en); end
    n_vec++; if ({maddr0, maddr1, maddr2, maddr3} !== {12'h005, 12'h010, 12'h020, 12'h030}) begin
      n_err++; $display("FAIL nc_addr: got %h %h %h %h expected 005 010 020 030", maddr0, maddr1, maddr2, maddr3); end
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 4'b1111) begin n_err++; $display("FAIL nc_rsp_valid: got %b expected 1111", rsp_valid); end
    n_vec++; if (rsp_a !== mk(0, 12'h005)) begin n_err++; $display("FAIL nc_data_a: got %h expected %h", rsp_a, mk(0, 12'h005)); end
    n_vec++; if (rsp_b !== mk(1, 12'h010)) begin n_err++; $display("FAIL nc_data_b: got %h expected %h", rsp_b, mk(1, 12'h010)); end
    n_vec++; if (rsp_d !== mk(3, 12'h030)) begin n_err++; $display("FAIL nc_data_d: got %h expected %h", rsp_d, mk(3, 12'h030)); end
    n_vec++; if (cnt !== 16'd0) begin n_err++; $display("FAIL nc_cnt: got %h expected 0000", cnt); end
    @(negedge clk);
    set_req(4'b0000, '0, '0, '0, '0);
    #1;
    n_vec++; if (mem_en !== 4'b0000 || maddr1 !== 12'h000) begin
      n_err++; $display("FAIL nc_idle: got en=%b addr1=%h expected 0000/000", mem_en, maddr1); end
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 4'b0000 || rsp_a !== 64'd0) begin
      n_err++; $display("FAIL nc_rsp_idle: got %b %h expected 0000/0", rsp_valid, rsp_a); end
  endtask

`ifdef BANK_ARB_RR_EN
  task automatic test_arbitration();
    logic [13:0] aa, ab, ac, ad;
    aa = {2'd1, 12'h011}; ab = {2'd1, 12'h022}; ac = {2'd1, 12'h033}; ad = {2'd1, 12'h044};
    do_reset();
    set_req(4'b1111, aa, ab, ac, ad);
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rr_g0: got %b expected 0001", req_ready); end
    @(posedge clk); #1;
    n_vec++; if (rsp_a !== mk(1, 12'h011)) begin n_err++; $display("FAIL rr_data_a: got %h expected %h", rsp_a, mk(1, 12'h011)); end
    @(negedge clk); set_req(4'b1110, aa, ab, ac, ad); #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rr_g1: got %b expected 0010", req_ready); end
    @(negedge clk); set_req(4'b1100, aa, ab, ac, ad); #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL rr_g2: got %b expected 0100", req_ready); end
    @(negedge clk); set_req(4'b1000, aa, ab, ac, ad); #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rr_g3: got %b expected 1000", req_ready); end
    @(posedge clk); #1;
    n_vec++; if (cnt !== 16'd3) begin n_err++; $display("FAIL rr_cnt: got %0d expected 3", cnt); end
    n_vec++; if (rsp_d !== mk(1, 12'h044)) begin n_err++; $display("FAIL rr_data_d: got %h expected %h", rsp_d, mk(1, 12'h044)); end
    @(negedge clk); set_req(4'b0001, aa, ab, ac, ad); #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rr_g4: got %b expected 0001", req_ready); end
    // pointer is now 1: search 1,2,3,0 lets D beat A
    @(negedge clk); set_req(4'b1001, aa, ab, ac, ad); #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rr_wrap: got %b expected 1000", req_ready); end
    @(posedge clk); #1;
    n_vec++; if (cnt !== 16'd4) begin n_err++; $display("FAIL rr_cnt2: got %0d expected 4", cnt); end
  endtask
`else
  task automatic test_arbitration();
    do_reset();
    set_req(4'b1111, {2'd2, 12'h100}, {2'd2, 12'h200}, {2'd3, 12'h300}, {2'd3, 12'h3FF});
    #1;
    n_vec++; if (req_ready !== 4'b0110) begin n_err++; $display("FAIL fp_g0: got %b expected 0110", req_ready); end
    n_vec++; if (maddr2 !== 12'h200) begin n_err++; $display("FAIL fp_addr2: got %h expected 200", maddr2); end
    @(posedge clk); #1;
    n_vec++; if (rsp_b !== mk(2, 12'h200)) begin n_err++; $display("FAIL fp_data_b: got %h expected %h", rsp_b, mk(2, 12'h200)); end
    n_vec++; if (rsp_c !== mk(3, 12'h300)) begin n_err++; $display("FAIL fp_data_c: got %h expected %h", rsp_c, mk(3, 12'h300)); end
    n_vec++; if (cnt !== 16'd1) begin n_err++; $display("FAIL fp_cnt: got %0d expected 1", cnt); end
    @(negedge clk);
    set_req(4'b1001, {2'd2, 12'h100}, {2'd2, 12'h200}, {2'd3, 12'h300}, {2'd3, 12'h3FF});
    #1;
    n_vec++; if (req_ready !== 4'b1001) begin n_err++; $display("FAIL fp_g1: got %b expected 1001", req_ready); end
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 4'b1001) begin n_err++; $display("FAIL fp_rsp_valid: got %b expected 1001", rsp_valid); end
    n_vec++; if (rsp_a !== mk(2, 12'h100)) begin n_err++; $display("FAIL fp_data_a: got %h expected %h", rsp_a, mk(2, 12'h100)); end
    n_vec++; if (rsp_d !== mk(3, 12'h3FF)) begin n_err++; $display("FAIL fp_data_d: got %h expected %h", rsp_d, mk(3, 12'h3FF)); end
    n_vec++; if (cnt !== 16'd1) begin n_err++; $display("FAIL fp_cnt2: got %0d expected 1", cnt); end
  endtask
`endif

  task automatic test_preempt();
    do_reset();
    ctrl_en = 1'b1; ctrl_addr = 12'h7FF;
    uinst_en = 1'b1; uinst_addr = 12'h123;
    set_req(4'b0111, {2'd0, 12'h055}, {2'd1, 12'h066}, {2'd2, 12'h077}, '0);
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL pre_ready%0d: got %b expected 0010", i, req_ready); end
      n_vec++; if (maddr0 !== 12'h7FF || maddr2 !== 12'h123) begin
        n_err++; $display("FAIL pre_addr%0d: got %h %h expected 7FF 123", i, maddr0, maddr2); end
      @(posedge clk); #1;
      n_vec++; if ({ctrl_rv, uinst_rv} !== 2'b11) begin n_err++; $display("FAIL pre_rv%0d: got %b expected 11", i, {ctrl_rv, uinst_rv}); end
      n_vec++; if (cnt !== 16'd0) begin n_err++; $display("FAIL pre_cnt%0d: got %0d expected 0", i, cnt); end
      @(negedge clk);
    end
    ctrl_en = 1'b0; uinst_en = 1'b0;
    set_req(4'b0101, {2'd0, 12'h055}, '0, {2'd2, 12'h077}, '0);
    #1;
    n_vec++; if (req_ready !== 4'b0101 || maddr0 !== 12'h055) begin
      n_err++; $display("FAIL pre_release: got %b %h expected 0101 055", req_ready, maddr0); end
    @(posedge clk); #1;
    n_vec++; if ({ctrl_rv, uinst_rv} !== 2'b00) begin n_err++; $display("FAIL pre_rv_off: got %b expected 00", {ctrl_rv, uinst_rv}); end
    n_vec++; if (rsp_a !== mk(0, 12'h055)) begin n_err++; $display("FAIL pre_data_a: got %h expected %h", rsp_a, mk(0, 12'h055)); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_req(4'b0001, {2'd0, 12'(12'h040 + i)}, '0, '0, '0);
      #1;
      n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL b2b_ready%0d: got %b expected 0001", i, req_ready); end
      @(posedge clk); #1;
      n_vec++; if (rsp_valid !== 4'b0001 || rsp_a !== mk(0, 12'(12'h040 + i))) begin
        n_err++; $display("FAIL b2b_rsp%0d: got %b %h expected 0001 %h", i, rsp_valid, rsp_a, mk(0, 12'(12'h040 + i))); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    set_req(4'b1100, '0, '0, {2'd3, 12'h0AA}, {2'd3, 12'h0AB});
    @(negedge clk);
    set_req(4'b1000, '0, '0, '0, {2'd3, 12'h0AB});
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL mid_ready: got %b expected 1000", req_ready); end
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 4'b1000 || cnt !== 16'd1) begin
      n_err++; $display("FAIL mid_pre: got %b cnt=%0d expected 1000 cnt=1", rsp_valid, cnt); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (rsp_valid !== 4'b0000 || rsp_d !== 64'd0) begin
      n_err++; $display("FAIL mid_async: got %b %h expected 0000/0", rsp_valid, rsp_d); end
    n_vec++; if (cnt !== 16'd0 || req_ready !== 4'b0000) begin
      n_err++; $display("FAIL mid_clear: got cnt=%0d ready=%b expected 0/0000", cnt, req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(4'b0000, '0, '0, '0, '0);
    @(posedge clk); #1;
    n_vec++; if (rsp_valid !== 4'b0000) begin n_err++; $display("FAIL mid_after: got %b expected 0000", rsp_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    set_req(4'b0011, {2'd1, 12'h001}, {2'd1, 12'h002}, '0, '0);
    repeat (65534) @(posedge clk);
    #1;
    n_vec++; if (cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe: got %h expected FFFE", cnt); end
    @(posedge clk); #1;
    n_vec++; if (cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff: got %h expected FFFF", cnt); end
    repeat (5) @(posedge clk);
    #1;
    n_vec++; if (cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_hold: got %h expected FFFF", cnt); end
  endtask

  initial begin
    test_reset();
    test_no_conflict();
    test_arbitration();
    test_preempt();
    test_back_to_back();
    test_reset_midop();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_bank_arbiter.md
# mem_bank_arbiter

Arbitrates four datapath read requesters (A, B, C, D) onto the four single-port read banks: mem0 port 0, mem0 port 1, mem1 port 0 and mem1 port 1. The bank is selected by the top two bits of each 14-bit request address. Conflicting requesters are stalled with a valid/ready handshake instead of being silently overridden. The block tracks which requester owns each bank for the 1-cycle synchronous read and returns tagged read data. Control-fetch and micro-instruction-fetch ports preempt banks 0 and 2. It sits between the operand-fetch sequencer and the RAM macros, replacing static address steering.

## Interface
- ADDR_WIDTH, 12, word address width inside one bank; request address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 64, read data width.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  4  per-requester request (bit0=A, 1=B, 2=C, 3=D)
- req_addr_a/b/c/d  in  ADDR_WIDTH+2  [ADDR_WIDTH+1:ADDR_WIDTH] selects bank, low bits select word
- req_ready  out  4  grant this cycle; transfer when valid&ready
- rsp_valid  out  4  read data for requester valid this cycle
- rsp_data_a/b/c/d  out  DATA_WIDTH  read data
- ctrl_en, ctrl_addr  in  1, ADDR_WIDTH  control fetch, preempts bank 0
- uinst_en, uinst_addr  in  1, ADDR_WIDTH  micro-instruction fetch, preempts bank 2
- ctrl_rsp_valid, uinst_rsp_valid  out  1  preempt read data valid; data taken from mem_rd_data_0 / mem_rd_data_2
- mem_en  out  4  bank read enable
- mem_addr_0..3  out  ADDR_WIDTH  bank addresses
- mem_rd_data_0..3  in  DATA_WIDTH  bank read data, 1 cycle after mem_en
- conflict_cnt  out  16  saturating stall-cycle counter

## Operation
- Each bank k independently grants at most one source per cycle. Candidates are requesters with req_valid=1 and bank field = k.
- ctrl_en=1 owns bank 0 and uinst_en=1 owns bank 2. While a bank is preempted, every requester targeting it sees ready=0 and that bank's pointer does not move.
- req_ready[r]=1 only if req_valid[r]=1 and r won its bank. It is purely combinational from the current inputs.
- Requesters hold valid and addr stable until ready. The arbiter does not check this.
- Granted bank: mem_en[k]=1, and mem_addr_k = the winner's low ADDR_WIDTH bits (or ctrl_addr / uinst_addr when preempted).
- Idle bank: mem_en[k]=0, mem_addr_k=0.
- Grant pipeline register stores, per requester, the rsp pending bit and the 2-bit source bank.
- In the next cycle, rsp_valid[r]=1 and rsp_data_r = mem_rd_data_<bank>.
- While rsp_valid[r]=0, rsp_data_r is 0.
- ctrl_rsp_valid and uinst_rsp_valid are the preempt enables delayed by one cycle.
- Priority within a bank with BANK_ARB_RR_EN defined:
  - Round-robin. Per-bank 2-bit pointer ptr_k gives the highest-priority index; search order is ptr_k, ptr_k+1, … mod 4.
  - On a requester grant to r, ptr_k <= (r+1) mod 4.
- conflict_cnt increments by 1 in any cycle where at least one valid requester is denied because another requester won its bank. Preemption denials do not count. The counter saturates at 0xFFFF.

## Timing
- Reset (async assert, sync to clk on release):
  - rsp_valid=0, ctrl_rsp_valid=0, uinst_rsp_valid=0, conflict_cnt=0, all ptr_k=0, and all pending tags cleared.
  - Combinational outputs follow the inputs, but req_ready and mem_en are forced 0 while rst_n=0.
- Latency: request handshaken in cycle N → rsp_valid in cycle N+1, exactly one cycle. No back-pressure on responses.
- Simultaneous events:
  - A requester may be granted in the same cycle its previous response is returned (full throughput, one read per bank per cycle).
  - Two requesters sharing an address in the same bank still serialize.
- Reset mid-operation: pending responses are dropped and never presented after reset release.

## Configuration
- BANK_ARB_RR_EN defined: per-bank round-robin pointers as above.
- BANK_ARB_RR_EN undefined: fixed priority B > A > C > D on every bank. No pointers are synthesized. All other behaviour is identical.

## Test plan
- No conflict: A→bank0 addr 0x005, B→bank1 0x010, C→bank2 0x020, D→bank3 0x030, all valid → req_ready=4'b1111 in cycle 0; cycle 1 rsp_valid=4'b1111, rsp_data_a = mem_rd_data_0; conflict_cnt stays 0.
- RR (macro on): all four hold valid on bank 1 → grants A, B, C, D, A in successive cycles; conflict_cnt=3 after the 4th grant cycle, with requests dropping as served.
- Fixed priority (macro off): A and B both valid on bank 2 → B granted cycle 0, A cycle 1; rsp_data_b = mem_rd_data_2 in cycle 1.
- Preempt: ctrl_en=1, ctrl_addr=0x7FF, A valid on bank 0 for 2 cycles → mem_addr_0=0x7FF, req_ready[0]=0, conflict_cnt unchanged; ctrl_rsp_valid=1 next cycle; A granted on the first cycle ctrl_en=0.
- Reset mid-op: grant D on bank 3, drop rst_n before the next edge → rsp_valid=0 immediately and stays 0 after release; conflict_cnt=0.
- Saturation: force a continuous conflict for 65 540 cycles → conflict_cnt holds 0xFFFF.
